tantra_lif_core: RTL and testbench
==================================

Name: tantra_lif_core

Overview:
- Parametrised, time-multiplexed leaky-integrate-and-fire layer; successor to the fixed 7x8 chakra network.
- One instance is one chakra layer with NUM_IN presynaptic inputs and NUM_NEUR neurons.
- Instances chain through a valid/ready step handshake. Weights are runtime-writable.
- Adds refractory period, saturating signed arithmetic, runtime threshold, fixed-latency sequential scheduling, and optional STDP (tapas/vairagya).

Parameters:
- NUM_IN, 8, presynaptic inputs per step.
- NUM_NEUR, 8, neurons (lotus petals) in layer.
- W_WIDTH, 8, signed weight width.
- V_WIDTH, 16, membrane width; unsigned, clamped to [0, 2^V_WIDTH-1].
- LEAK_SHIFT, 4, leak = V >> LEAK_SHIFT per step.
- REFRACTORY, 2, steps a neuron is silent after firing (0 = none).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- step_valid  in  1  input spike vector valid.
- step_ready  out  1  core idle, can accept step.
- in_spikes  in  NUM_IN  presynaptic spikes for this step.
- threshold  in  V_WIDTH  fire threshold; sampled at handshake.
- wr_en  in  1  weight write strobe.
- wr_pre  in  clog2(NUM_IN)  weight row.
- wr_post  in  clog2(NUM_NEUR)  weight column.
- wr_data  in  W_WIDTH  signed weight.
- rd_pre / rd_post  in  as wr_*  debug read address.
- rd_data  out  W_WIDTH  combinational weight[rd_pre][rd_post].
- learning_rate  in  W_WIDTH-1  STDP step, unsigned; sampled at handshake.
- out_valid  out  1  one-cycle pulse: out_spikes updated.
- out_spikes  out  NUM_NEUR  spikes of the last completed step; held until next out_valid.
- spike_total  out  16  cumulative output spikes; saturates at 65535.

Behaviour:
- Reset, any state, including mid-step: FSM goes to IDLE; step_ready=1, out_valid=0, out_spikes=0, spike_total=0. V, refractory counters, accumulators and all weights are cleared to 0.
- FSM states:
  - IDLE: step_ready=1. On step_valid && step_ready, latch in_spikes, threshold and learning_rate, then go to ACCUM.
  - ACCUM: exactly NUM_IN*NUM_NEUR cycles, post-major order: pre 0..NUM_IN-1 for post 0, then post 1, and so on. Each cycle, if the latched spike[pre] is set, acc[post] += w[pre][post] (signed). ACC width = W_WIDTH + clog2(NUM_IN) + 1, so it never overflows.
  - UPDATE: NUM_NEUR cycles, neuron n on cycle n.
    - If refr[n] != 0: refr[n]--, V[n]=0, no spike, acc discarded.
    - Else: Vn = V - (V >> LEAK_SHIFT) + acc, computed signed, then clamped to [0, 2^V_WIDTH-1].
    - If Vn >= threshold: spike[n]=1, V[n]=0, refr[n]=REFRACTORY. Else V[n]=Vn.
    - acc[n] is cleared either way.
  - LEARN: only when STDP_EN is defined; see Optional Feature.
  - DONE: one cycle. out_valid=1, out_spikes updated, spike_total += popcount (saturating). Then go to IDLE.
- Latency, handshake cycle = 0: out_valid at cycle NUM_IN*NUM_NEUR + NUM_NEUR + 1. With STDP_EN, add NUM_IN*NUM_NEUR.
- step_valid while not IDLE: ignored; the step is not consumed.
- Weight writes:
  - Accepted only in IDLE; wr_en in any other state is dropped.
  - A write in the same cycle as a step handshake commits before ACCUM, so the step sees the new weight.
  - Out-of-range addresses (non-power-of-2 sizes) are ignored; reads of them return 0.
- threshold = 0: every non-refractory neuron fires each step.

Optional Feature:
- Macro: TANTRA_STDP_EN.
- Defined:
  - A LEARN state follows UPDATE and runs NUM_IN*NUM_NEUR cycles, same order as ACCUM.
  - For each post neuron that spiked this step: if spike[pre] was latched, w += learning_rate (tapas); else w -= learning_rate (vairagya). Results saturate to [-2^(W_WIDTH-1), 2^(W_WIDTH-1)-1].
  - Neurons that did not spike leave their weights unchanged.
  - wr_en is still blocked during LEARN.
- Undefined: no LEARN state; learning_rate is unused; weights change only via the write port.

Test Plan:
- Defaults throughout except NUM_IN=4, NUM_NEUR=4, threshold=100.
- Reset: assert rst mid-ACCUM -> next cycle step_ready=1, out_valid=0, out_spikes=0, spike_total=0, rd_data=0 for all addresses.
- Integrate/leak: w[0][1]=60; two steps with in_spikes=0001:
  - step 1 -> out_spikes=0000; out_valid exactly 21 cycles after handshake.
  - step 2 -> V=60-3+60=117, out_spikes=0010, spike_total=1.
- Refractory: w[0][1]=120; four steps with in=0001 -> out_spikes bit1 = 1,0,0,1; spike_total=2.
- Inhibition clamp: w[0][2]=-50, w[1][2]=30; step in=0011 -> acc=-20, V[2] stays 0, no spike. Next step with in=0010 -> V=30.
- Busy rules: step_valid and wr_en (w[3][3]=99) pulsed during UPDATE -> second step not consumed; rd_data for [3][3] still 0; only one out_valid.
- STDP (macro on), learning_rate=16, w[0][0]=120, w[1][0]=-120:
  - step in=0001 -> neuron 0 fires; w[0][0]=127 (saturated), w[1][0]=-128 (saturated), w[2][0]=-16.
  - out_valid at cycle 37.

Source files
------------

// File: rtl/tantra_lif_core_if.sv
// Step handshake bundle for one tantra_lif_core layer: the input spike step
// (valid/ready, spikes, threshold, learning rate) and the completed-step output.
interface tantra_lif_core_if #(
  parameter int NUM_IN   = 8,
  parameter int NUM_NEUR = 8,
  parameter int W_WIDTH  = 8,
  parameter int V_WIDTH  = 16
);
  logic                step_valid;
  logic                step_ready;
  logic [NUM_IN-1:0]   in_spikes;
  logic [V_WIDTH-1:0]  threshold;
  logic [W_WIDTH-2:0]  learning_rate;
  logic                out_valid;
  logic [NUM_NEUR-1:0] out_spikes;

  modport master (
    output step_valid, in_spikes, threshold, learning_rate,
    input  step_ready, out_valid, out_spikes
  );

  modport slave (
    input  step_valid, in_spikes, threshold, learning_rate,
    output step_ready, out_valid, out_spikes
  );
endinterface

// File: rtl/tantra_lif_core.sv
// Time-multiplexed leaky-integrate-and-fire layer with refractory period,
// saturating arithmetic and optional STDP (macro TANTRA_STDP_EN).
// Ports: clk, rst (sync, active high); s = step handshake/output interface;
// wr_* = weight write port (IDLE only); rd_pre/rd_post -> rd_data (comb);
// spike_total = saturating cumulative spike count.
module tantra_lif_core #(
  parameter int NUM_IN     = 8,
  parameter int NUM_NEUR   = 8,
  parameter int W_WIDTH    = 8,
  parameter int V_WIDTH    = 16,
  parameter int LEAK_SHIFT = 4,
  parameter int REFRACTORY = 2,
  localparam int PW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
  localparam int QW = (NUM_NEUR > 1) ? $clog2(NUM_NEUR) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  tantra_lif_core_if.slave          s,
  input  logic                      wr_en,
  input  logic [PW-1:0]             wr_pre,
  input  logic [QW-1:0]             wr_post,
  input  logic signed [W_WIDTH-1:0] wr_data,
  input  logic [PW-1:0]             rd_pre,
  input  logic [QW-1:0]             rd_post,
  output logic signed [W_WIDTH-1:0] rd_data,
  output logic [15:0]               spike_total
);

  localparam int AW = W_WIDTH + $clog2(NUM_IN) + 1;
  localparam int SW = ((V_WIDTH > AW) ? V_WIDTH : AW) + 2;
  localparam int RW = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

  typedef enum logic [2:0] {IDLE, ACCUM, UPDATE, LEARN, DONE} state_e;

  state_e state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [QW-1:0] post_q, post_d;
  logic [NUM_IN-1:0] spk_in_q, spk_in_d;
  logic [NUM_NEUR-1:0] spk_q, spk_d;
  logic [V_WIDTH-1:0] thr_q, thr_d;
  logic [NUM_NEUR-1:0] out_spikes_q, out_spikes_d;
  logic [15:0] total_q, total_d;
  logic signed [W_WIDTH-1:0] w_q [NUM_IN][NUM_NEUR];
  logic signed [W_WIDTH-1:0] w_d [NUM_IN][NUM_NEUR];
  logic signed [AW-1:0] acc_q [NUM_NEUR];
  logic signed [AW-1:0] acc_d [NUM_NEUR];
  logic [V_WIDTH-1:0] v_q [NUM_NEUR];
  logic [V_WIDTH-1:0] v_d [NUM_NEUR];
  logic [RW-1:0] refr_q [NUM_NEUR];
  logic [RW-1:0] refr_d [NUM_NEUR];

  logic last_pre, last_post, wr_ok, rd_ok;
  logic signed [SW-1:0] v_ext, leak_ext, acc_ext, vn_s;
  logic [V_WIDTH-1:0] vn;
  logic [15:0] pop_c;
  logic [16:0] sum17;

`ifdef TANTRA_STDP_EN
  logic [W_WIDTH-2:0] lr_q, lr_d;
  logic signed [W_WIDTH:0] ws, wn_s;
  logic signed [W_WIDTH-1:0] wn;
`else
  logic unused_lr;
  assign unused_lr = ^s.learning_rate;
`endif

  assign last_pre  = (pre_q == PW'(NUM_IN - 1));
  assign last_post = (post_q == QW'(NUM_NEUR - 1));
  assign wr_ok = (32'(wr_pre) < NUM_IN) && (32'(wr_post) < NUM_NEUR);
  assign rd_ok = (32'(rd_pre) < NUM_IN) && (32'(rd_post) < NUM_NEUR);
  assign rd_data = rd_ok ? w_q[rd_pre][rd_post] : '0;

  assign s.step_ready = (state_q == IDLE);
  assign s.out_valid  = (state_q == DONE);
  assign s.out_spikes = out_spikes_q;
  assign spike_total  = total_q;

  always_comb begin
    state_d      = state_q;
    pre_d        = pre_q;
    post_d       = post_q;
    spk_in_d     = spk_in_q;
    spk_d        = spk_q;
    thr_d        = thr_q;
    out_spikes_d = out_spikes_q;
    total_d      = total_q;
    w_d          = w_q;
    acc_d        = acc_q;
    v_d          = v_q;
    refr_d       = refr_q;
    pop_c        = '0;
    sum17        = '0;

    // Membrane update for the neuron addressed by post_q, clamped to the
    // unsigned membrane range.
    v_ext    = SW'(v_q[post_q]);
    leak_ext = SW'(v_q[post_q] >> LEAK_SHIFT);
    acc_ext  = SW'(acc_q[post_q]);
    vn_s     = v_ext - leak_ext + acc_ext;
    if (vn_s[SW-1])
      vn = '0;
    else if (|vn_s[SW-2:V_WIDTH])
      vn = '1;
    else
      vn = vn_s[V_WIDTH-1:0];

`ifdef TANTRA_STDP_EN
    lr_d = lr_q;
    ws   = {w_q[pre_q][post_q][W_WIDTH-1], w_q[pre_q][post_q]};
    if (spk_in_q[pre_q])
      wn_s = ws + $signed({2'b00, lr_q});
    else
      wn_s = ws - $signed({2'b00, lr_q});
    // Out of range when the two top bits disagree; sign picks the rail.
    if (wn_s[W_WIDTH] != wn_s[W_WIDTH-1])
      wn = wn_s[W_WIDTH] ? {1'b1, {(W_WIDTH-1){1'b0}}}
                         : {1'b0, {(W_WIDTH-1){1'b1}}};
    else
      wn = wn_s[W_WIDTH-1:0];
`endif

    unique case (state_q)
      IDLE: begin
        if (wr_en && wr_ok)
          w_d[wr_pre][wr_post] = wr_data;
        if (s.step_valid) begin
          spk_in_d = s.in_spikes;
          thr_d    = s.threshold;
`ifdef TANTRA_STDP_EN
          lr_d     = s.learning_rate;
`endif
          spk_d    = '0;
          pre_d    = '0;
          post_d   = '0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        if (spk_in_q[pre_q])
          acc_d[post_q] = acc_q[post_q] + AW'(w_q[pre_q][post_q]);
        pre_d = last_pre ? '0 : pre_q + 1'b1;
        if (last_pre) begin
          post_d = last_post ? '0 : post_q + 1'b1;
          if (last_post)
            state_d = UPDATE;
        end
      end
      UPDATE: begin
        acc_d[post_q] = '0;
        if (refr_q[post_q] != '0) begin
          refr_d[post_q] = refr_q[post_q] - 1'b1;
          v_d[post_q]    = '0;
        end else if (vn >= thr_q) begin
          spk_d[post_q]  = 1'b1;
          v_d[post_q]    = '0;
          refr_d[post_q] = RW'(REFRACTORY);
        end else begin
          v_d[post_q] = vn;
        end
        post_d = last_post ? '0 : post_q + 1'b1;
        if (last_post) begin
          pre_d = '0;
`ifdef TANTRA_STDP_EN
          state_d = LEARN;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef TANTRA_STDP_EN
      LEARN: begin
        if (spk_q[post_q])
          w_d[pre_q][post_q] = wn;
        pre_d = last_pre ? '0 : pre_q + 1'b1;
        if (last_pre) begin
          post_d = last_post ? '0 : post_q + 1'b1;
          if (last_post)
            state_d = DONE;
        end
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Publish results on entry to DONE so they coincide with out_valid.
    if (state_d == DONE && state_q != DONE) begin
      out_spikes_d = spk_d;
      for (int i = 0; i < NUM_NEUR; i++)
        pop_c = pop_c + 16'(spk_d[i]);
      sum17   = {1'b0, total_q} + {1'b0, pop_c};
      total_d = sum17[16] ? 16'hFFFF : sum17[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pre_q        <= '0;
      post_q       <= '0;
      spk_in_q     <= '0;
      spk_q        <= '0;
      thr_q        <= '0;
      out_spikes_q <= '0;
      total_q      <= '0;
      w_q          <= '{default: '0};
      acc_q        <= '{default: '0};
      v_q          <= '{default: '0};
      refr_q       <= '{default: '0};
`ifdef TANTRA_STDP_EN
      lr_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      post_q       <= post_d;
      spk_in_q     <= spk_in_d;
      spk_q        <= spk_d;
      thr_q        <= thr_d;
      out_spikes_q <= out_spikes_d;
      total_q      <= total_d;
      w_q          <= w_d;
      acc_q        <= acc_d;
      v_q          <= v_d;
      refr_q       <= refr_d;
`ifdef TANTRA_STDP_EN
      lr_q         <= lr_d;
`endif
    end
  end

endmodule

// File: tb/tb_tantra_lif_core.sv
// Directed self-checking bench for tantra_lif_core (NUM_IN=4, NUM_NEUR=4).
// Covers reset, integrate/leak, refractory, clamp, busy rules and STDP.
module tb_tantra_lif_core;

`ifdef TANTRA_STDP_EN
  localparam int LAT = 37;
`else
  localparam int LAT = 21;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_pre = '0;
  logic [1:0] wr_post = '0;
  logic [7:0] wr_data = '0;
  logic [1:0] rd_pre = '0;
  logic [1:0] rd_post = '0;
  logic [7:0] rd_data;
  logic [15:0] spike_total;

  int checks = 0;
  int failures = 0;
  int lat;
  int n;
  int ov;

  tantra_lif_core_if #(
    .NUM_IN(4), .NUM_NEUR(4), .W_WIDTH(8), .V_WIDTH(16)
  ) sif ();

  tantra_lif_core #(
    .NUM_IN(4), .NUM_NEUR(4), .W_WIDTH(8), .V_WIDTH(16),
    .LEAK_SHIFT(4), .REFRACTORY(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s(sif.slave),
    .wr_en(wr_en),
    .wr_pre(wr_pre),
    .wr_post(wr_post),
    .wr_data(wr_data),
    .rd_pre(rd_pre),
    .rd_post(rd_post),
    .rd_data(rd_data),
    .spike_total(spike_total)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr_w(input logic [1:0] p, input logic [1:0] q,
                      input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_pre = p;
    wr_post = q;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd_w(input logic [1:0] p, input logic [1:0] q,
                      output logic [7:0] d);
    rd_pre = p;
    rd_post = q;
    #1;
    d = rd_data;
  endtask

  // Latency counts cycles from the handshake cycle to the out_valid cycle.
  task automatic do_step(input logic [3:0] in, input logic [15:0] thr,
                         input logic [6:0] lr, output int l);
    int k;
    @(negedge clk);
    sif.step_valid = 1'b1;
    sif.in_spikes = in;
    sif.threshold = thr;
    sif.learning_rate = lr;
    @(negedge clk);
    sif.step_valid = 1'b0;
    k = 1;
    while (!sif.out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    l = sif.out_valid ? k : 0;
  endtask

  logic [7:0] rv;

  initial begin
    sif.step_valid = 1'b0;
    sif.in_spikes = '0;
    sif.threshold = '0;
    sif.learning_rate = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_ready", 32'(sif.step_ready), 32'd1);
    chk("rst_valid", 32'(sif.out_valid), 32'd0);
    chk("rst_total", 32'(spike_total), 32'd0);

    // Reset mid-ACCUM after a step has produced a spike.
    wr_w(2'd0, 2'd0, 8'd120);
    wr_w(2'd3, 2'd2, 8'hFB);
    do_step(4'b0001, 16'd100, 7'd0, lat);
    chk("pre_spikes", 32'(sif.out_spikes), 32'h1);
    chk("pre_total", 32'(spike_total), 32'd1);
    @(negedge clk);
    sif.step_valid = 1'b1;
    sif.in_spikes = 4'b1001;
    sif.threshold = 16'd100;
    @(negedge clk);
    sif.step_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", 32'(sif.step_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_ready", 32'(sif.step_ready), 32'd1);
    chk("mrst_valid", 32'(sif.out_valid), 32'd0);
    chk("mrst_spikes", 32'(sif.out_spikes), 32'd0);
    chk("mrst_total", 32'(spike_total), 32'd0);
    rst = 1'b0;
    for (int p = 0; p < 4; p++)
      for (int q = 0; q < 4; q++) begin
        rd_w(2'(p), 2'(q), rv);
        chk($sformatf("mrst_w%0d%0d", p, q), 32'(rv), 32'd0);
      end

    // Integrate and leak: 60, then 60 - 3 + 60 = 117 >= 100.
    wr_w(2'd0, 2'd1, 8'd60);
    do_step(4'b0001, 16'd100, 7'd0, lat);
    chk("int1_lat", 32'(lat), 32'(LAT));
    chk("int1_spk", 32'(sif.out_spikes), 32'h0);
    do_step(4'b0001, 16'd100, 7'd0, lat);
    chk("int2_spk", 32'(sif.out_spikes), 32'h2);
    chk("int2_total", 32'(spike_total), 32'd1);

    // Refractory: fire, two silent steps, fire again.
    do_reset();
    wr_w(2'd0, 2'd1, 8'd120);
    do_step(4'b0001, 16'd100, 7'd0, lat);
    chk("ref1", 32'(sif.out_spikes), 32'h2);
    do_step(4'b0001, 16'd100, 7'd0, lat);
    chk("ref2", 32'(sif.out_spikes), 32'h0);
    do_step(4'b0001, 16'd100, 7'd0, lat);
    chk("ref3", 32'(sif.out_spikes), 32'h0);
    do_step(4'b0001, 16'd100, 7'd0, lat);
    chk("ref4", 32'(sif.out_spikes), 32'h2);
    chk("ref_total", 32'(spike_total), 32'd2);

    // Inhibition clamps at 0; then V=30; then 30-1=29 fires at thr 29.
    do_reset();
    wr_w(2'd0, 2'd2, 8'hCE);
    wr_w(2'd1, 2'd2, 8'd30);
    do_step(4'b0011, 16'd100, 7'd0, lat);
    chk("inh1", 32'(sif.out_spikes), 32'h0);
    do_step(4'b0010, 16'd100, 7'd0, lat);
    chk("inh2", 32'(sif.out_spikes), 32'h0);
    do_step(4'b0000, 16'd29, 7'd0, lat);
    chk("inh3", 32'(sif.out_spikes), 32'h4);
    // Threshold 0: all fire except refractory neuron 2.
    do_step(4'b0000, 16'd0, 7'd0, lat);
    chk("thr0", 32'(sif.out_spikes), 32'hB);
    chk("thr0_total", 32'(spike_total), 32'd4);

    // Busy rules: step and write during UPDATE are dropped.
    do_reset();
    @(negedge clk);
    sif.step_valid = 1'b1;
    sif.in_spikes = 4'b0001;
    sif.threshold = 16'd100;
    sif.learning_rate = '0;
    @(negedge clk);
    sif.step_valid = 1'b0;
    n = 1;
    while (!sif.out_valid && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 17) begin
        chk("busy_ready", 32'(sif.step_ready), 32'd0);
        sif.step_valid = 1'b1;
        wr_en = 1'b1;
        wr_pre = 2'd3;
        wr_post = 2'd3;
        wr_data = 8'd99;
      end else if (n == 18) begin
        sif.step_valid = 1'b0;
        wr_en = 1'b0;
      end
    end
    sif.step_valid = 1'b0;
    wr_en = 1'b0;
    chk("busy_lat", 32'(sif.out_valid ? n : 0), 32'(LAT));
    ov = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (sif.out_valid) ov++;
    end
    chk("busy_extra", 32'(ov), 32'd0);
    chk("busy_idle", 32'(sif.step_ready), 32'd1);
    rd_w(2'd3, 2'd3, rv);
    chk("busy_w33", 32'(rv), 32'd0);

    // STDP: neuron 0 fires; its column learns when enabled.
    do_reset();
    wr_w(2'd0, 2'd0, 8'd120);
    wr_w(2'd1, 2'd0, 8'h88);
    do_step(4'b0001, 16'd100, 7'd16, lat);
    chk("stdp_spk", 32'(sif.out_spikes), 32'h1);
    chk("stdp_lat", 32'(lat), 32'(LAT));
`ifdef TANTRA_STDP_EN
    rd_w(2'd0, 2'd0, rv);
    chk("stdp_w00", 32'(rv), 32'h7F);
    rd_w(2'd1, 2'd0, rv);
    chk("stdp_w10", 32'(rv), 32'h80);
    rd_w(2'd2, 2'd0, rv);
    chk("stdp_w20", 32'(rv), 32'hF0);
    rd_w(2'd3, 2'd0, rv);
    chk("stdp_w30", 32'(rv), 32'hF0);
`else
    rd_w(2'd0, 2'd0, rv);
    chk("stdp_w00", 32'(rv), 32'h78);
    rd_w(2'd1, 2'd0, rv);
    chk("stdp_w10", 32'(rv), 32'h88);
    rd_w(2'd2, 2'd0, rv);
    chk("stdp_w20", 32'(rv), 32'h00);
`endif
    rd_w(2'd0, 2'd1, rv);
    chk("stdp_w01", 32'(rv), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
